// File: rtl/dbus_bridge_pkg.sv
// Shared types and defaults for the core data-port to system-bus bridge.
package dbus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } dbus_state_t;

  localparam logic [31:0] DBUS_ERR_DATA = 32'hDEAD_BEEF;
  localparam int          DBUS_TIMEOUT  = 255;

endpackage

// File: rtl/dbus_bridge.sv
// Turns a single core load/store into a valid/ready bus request plus a response
// wait with timeout, stalling the core until the result is presented.
module dbus_bridge
  import dbus_bridge_pkg::*;
#(
  parameter int          TIMEOUT  = DBUS_TIMEOUT,
  parameter logic [31:0] ERR_DATA = DBUS_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wr_data,
  output logic [31:0] d_rd_data,
  output logic        d_stall,
  output logic        d_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_data,
  input  logic        bus_rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  dbus_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             orphan;
  logic             unused_addr_lsb;

  // Byte offset is dropped: the bus only sees word addresses.
  assign unused_addr_lsb = ^d_addr[1:0];

  assign d_stall = (state == IDLE) ? d_req : (state != DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bus_req_valid <= 1'b0;
      bus_addr      <= '0;
      bus_wstrb     <= '0;
      bus_wdata     <= '0;
      d_rd_data     <= '0;
      d_err         <= 1'b0;
      orphan        <= 1'b0;
      cnt           <= '0;
    end else begin
      // A late response to an abandoned access is swallowed wherever it lands.
      if (orphan && bus_rsp_valid) begin
        orphan <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (d_req) begin
            bus_addr      <= {d_addr[31:2], 2'b00};
            bus_wstrb     <= d_we;
            bus_wdata     <= d_wr_data;
            bus_req_valid <= 1'b1;
            state         <= REQ;
          end
        end

        REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            cnt           <= '0;
            state         <= RSP;
          end
        end

        RSP: begin
          if (bus_rsp_valid) begin
            if (orphan) begin
              cnt <= '0;
            end else begin
              if (bus_wstrb == 4'b0000) begin
                d_rd_data <= bus_rsp_err ? ERR_DATA : bus_rsp_data;
              end
              d_err <= bus_rsp_err;
              state <= DONE;
            end
          end else if (cnt == CNT_LIMIT) begin
            d_rd_data <= ERR_DATA;
            d_err     <= 1'b1;
            orphan    <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed bench for dbus_bridge: stimulus pushes expected bus requests and core
// results into queues, a negedge monitor pops and compares them.
module tb_dbus_bridge;
  import dbus_bridge_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_we = '0;
  logic [31:0] d_wr_data = '0;
  logic [31:0] d_rd_data;
  logic        d_stall;
  logic        d_err;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid = 1'b0;
  logic [31:0] bus_rsp_data = '0;
  logic        bus_rsp_err = 1'b0;

  always #5 clk = ~clk;

  dbus_bridge #(.TIMEOUT(TO), .ERR_DATA(DBUS_ERR_DATA)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wr_data(d_wr_data),
    .d_rd_data(d_rd_data), .d_stall(d_stall), .d_err(d_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
    .bus_rsp_err(bus_rsp_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          vcyc;
  } req_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic        err;
    int          stalls;
  } rsp_exp_t;

  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_req(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input int v);
    req_exp_t r;
    r = '{a, s, d, v};
    req_q.push_back(r);
  endtask

  task automatic exp_rsp(input logic [31:0] d, input logic c, input logic e, input int s);
    rsp_exp_t r;
    r = '{d, c, e, s};
    rsp_q.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares request fields every valid cycle and the core result in DONE.
  initial begin
    int vcnt;
    int scnt;
    req_exp_t qe;
    rsp_exp_t re;
    vcnt = 0;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        vcnt = 0;
        scnt = 0;
      end else begin
        if (bus_req_valid) begin
          if (req_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_unexpected: got addr 0x%08h with no request pending", bus_addr);
          end else begin
            qe = req_q[0];
            check("bus_addr", bus_addr, qe.addr);
            check("bus_wstrb", 32'(bus_wstrb), 32'(qe.wstrb));
            check("bus_wdata", bus_wdata, qe.wdata);
            vcnt++;
            if (bus_req_ready) begin
              check("req_valid_cycles", vcnt, qe.vcyc);
              void'(req_q.pop_front());
              vcnt = 0;
            end
          end
        end
        if (d_req) begin
          if (d_stall) begin
            scnt++;
          end else if (rsp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_unexpected: got data 0x%08h with no access pending", d_rd_data);
          end else begin
            re = rsp_q.pop_front();
            check("d_err", 32'(d_err), 32'(re.err));
            if (re.chk_data) check("d_rd_data", d_rd_data, re.data);
            if (re.stalls >= 0) check("stall_cycles", scnt, re.stalls);
            scnt = 0;
          end
        end
      end
    end
  end

  task automatic core_access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    int n;
    n = 0;
    tick();
    d_req = 1'b1;
    d_addr = a;
    d_we = we;
    d_wr_data = wd;
    @(negedge clk);
    while (d_stall && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (d_stall) begin
      n_cmp++;
      n_bad++;
      $display("FAIL access_timeout: still stalled after %0d cycles, required 0", n);
    end
    tick();
    d_req = 1'b0;
    d_we = 4'b0000;
  endtask

  task automatic send_rsp(input logic [31:0] data, input logic err);
    bus_rsp_valid = 1'b1;
    bus_rsp_data = data;
    bus_rsp_err = err;
    tick();
    bus_rsp_valid = 1'b0;
    bus_rsp_err = 1'b0;
  endtask

  task automatic bus_serve(input int ready_wait, input int rsp_wait,
                           input logic [31:0] data, input logic err, input logic do_rsp);
    int n;
    n = 0;
    while (!bus_req_valid && n < 50) begin
      tick();
      n++;
    end
    if (!bus_req_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_wait: bus_req_valid got 0 after %0d cycles, required 1", n);
    end else begin
      repeat (ready_wait) tick();
      bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0;
      if (do_rsp) begin
        repeat (rsp_wait) tick();
        send_rsp(data, err);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_bus_req_valid", 32'(bus_req_valid), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_d_rd_data", d_rd_data, 32'd0);
    check("rst_d_err", 32'(d_err), 32'd0);
    check("rst_stall_lo", 32'(d_stall), 32'd0);
    d_req = 1'b1;
    #1;
    check("rst_stall_hi", 32'(d_stall), 32'd1);
    d_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Zero-wait load with unaligned address.
    exp_req(32'h0000_1000, 4'h0, 32'h0, 1);
    exp_rsp(32'h1234_5678, 1'b1, 1'b0, 3);
    fork
      core_access(32'h0000_1003, 4'h0, 32'h0);
      bus_serve(0, 0, 32'h1234_5678, 1'b0, 1'b1);
    join

    // Store held off by four cycles of backpressure.
    exp_req(32'h0000_2004, 4'hC, 32'hAABB_0000, 5);
    exp_rsp(32'h0, 1'b0, 1'b0, 7);
    fork
      core_access(32'h0000_2004, 4'hC, 32'hAABB_0000);
      bus_serve(4, 0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    join

    // Slave error, then a load proving no orphan was left behind.
    exp_req(32'h0000_3008, 4'h0, 32'h0, 1);
    exp_rsp(DBUS_ERR_DATA, 1'b1, 1'b1, 3);
    fork
      core_access(32'h0000_3008, 4'h0, 32'h0);
      bus_serve(0, 0, 32'h0000_0777, 1'b1, 1'b1);
    join
    exp_req(32'h0000_300C, 4'h0, 32'h0, 1);
    exp_rsp(32'h0000_9ABC, 1'b1, 1'b0, 3);
    fork
      core_access(32'h0000_300C, 4'h0, 32'h0);
      bus_serve(0, 0, 32'h0000_9ABC, 1'b0, 1'b1);
    join

    // Stray response in IDLE with no orphan is ignored.
    tick();
    send_rsp(32'hFFFF_0000, 1'b0);
    exp_req(32'h0000_4000, 4'h0, 32'h0, 1);
    exp_rsp(32'h0000_1111, 1'b1, 1'b0, 3);
    fork
      core_access(32'h0000_4000, 4'h0, 32'h0);
      bus_serve(0, 0, 32'h0000_1111, 1'b0, 1'b1);
    join

    // Timeout, late response lands in IDLE, then a normal load.
    exp_req(32'h0000_5000, 4'h0, 32'h0, 1);
    exp_rsp(DBUS_ERR_DATA, 1'b1, 1'b1, 2 + TO + 1);
    fork
      core_access(32'h0000_5000, 4'h0, 32'h0);
      bus_serve(0, 0, 32'h0, 1'b0, 1'b0);
    join
    tick();
    send_rsp(32'hBAD0_BAD0, 1'b0);
    exp_req(32'h0000_5004, 4'h0, 32'h0, 1);
    exp_rsp(32'h0000_0005, 1'b1, 1'b0, 3);
    fork
      core_access(32'h0000_5004, 4'h0, 32'h0);
      bus_serve(0, 0, 32'h0000_0005, 1'b0, 1'b1);
    join

    // Orphan race: stale response arrives inside the next access's RSP.
    exp_req(32'h0000_6000, 4'h0, 32'h0, 1);
    exp_rsp(DBUS_ERR_DATA, 1'b1, 1'b1, 2 + TO + 1);
    fork
      core_access(32'h0000_6000, 4'h0, 32'h0);
      bus_serve(0, 0, 32'h0, 1'b0, 1'b0);
    join
    exp_req(32'h0000_6004, 4'h0, 32'h0, 1);
    exp_rsp(32'h0000_0002, 1'b1, 1'b0, 6);
    fork
      core_access(32'h0000_6004, 4'h0, 32'h0);
      begin
        bus_serve(0, 0, 32'h0000_0001, 1'b0, 1'b1);
        tick();
        tick();
        send_rsp(32'h0000_0002, 1'b0);
      end
    join

    // Reset asserted while waiting in RSP.
    exp_req(32'h0000_7000, 4'h0, 32'h0, 1);
    tick();
    d_req = 1'b1;
    d_addr = 32'h0000_7000;
    d_we = 4'h0;
    bus_req_ready = 1'b1;
    tick();
    tick();
    bus_req_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rst_rsp_bus_req_valid", 32'(bus_req_valid), 32'd0);
    check("rst_rsp_stall_hi", 32'(d_stall), 32'd1);
    d_req = 1'b0;
    #1;
    check("rst_rsp_stall_lo", 32'(d_stall), 32'd0);
    check("rst_rsp_d_err", 32'(d_err), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    exp_req(32'h0000_7100, 4'h0, 32'h0, 1);
    exp_rsp(32'hCAFE_F00D, 1'b1, 1'b0, 3);
    fork
      core_access(32'h0000_7100, 4'h0, 32'h0);
      bus_serve(0, 0, 32'hCAFE_F00D, 1'b0, 1'b1);
    join

    repeat (3) tick();
    check("req_q_drained", req_q.size(), 32'd0);
    check("rsp_q_drained", rsp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
